// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller signal bundle with pipeline/controller modports
interface pipe_hazard_ctrl_if;
  logic [4:0] rs_ID;
  logic [4:0] rt_ID;
  logic       use_rs_ID;
  logic       use_rt_ID;
  logic       branch_ID;
  logic       mnd_ID;
  logic [4:0] A3_EX;
  logic       GprWrite_EX;
  logic       Mem2Gpr_EX;
  logic       mnd_start_EX;
  logic       mnd_div_EX;
  logic [4:0] A3_MEM;
  logic       Mem2Gpr_MEM;
  logic       Exception;
  logic       int_req;
  logic       IE;
  logic       is_eret_MEM;
  logic       En_IF;
  logic       En_ID;
  logic       Clr_ID;
  logic       Clr_EX;
  logic       Clr_MEM;
  logic [1:0] PC_sel;
  logic       exl;
  logic       mnd_busy;

  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, branch_ID, mnd_ID,
    output A3_EX, GprWrite_EX, Mem2Gpr_EX, mnd_start_EX, mnd_div_EX,
    output A3_MEM, Mem2Gpr_MEM, Exception, int_req, IE, is_eret_MEM,
    input  En_IF, En_ID, Clr_ID, Clr_EX, Clr_MEM, PC_sel, exl, mnd_busy
  );

  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, branch_ID, mnd_ID,
    input  A3_EX, GprWrite_EX, Mem2Gpr_EX, mnd_start_EX, mnd_div_EX,
    input  A3_MEM, Mem2Gpr_MEM, Exception, int_req, IE, is_eret_MEM,
    output En_IF, En_ID, Clr_ID, Clr_EX, Clr_MEM, PC_sel, exl, mnd_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with mult/div busy counter and EXL bit
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  pipe_hazard_ctrl_if.slave  bus
);

  logic             r_exl;
  logic [CNT_W-1:0] r_cnt;

  logic w_hit_e;
  logic w_hit_m;
  logic w_load_use;
  logic w_br_dep;
  logic w_md_dep;
  logic w_stall;
  logic w_take_int;
  logic w_flush;
  logic w_cnt_nz;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign w_hit_e = (bus.A3_EX != 5'd0) &&
                   ((bus.use_rs_ID && (bus.rs_ID == bus.A3_EX)) ||
                    (bus.use_rt_ID && (bus.rt_ID == bus.A3_EX)));
  assign w_hit_m = (bus.A3_MEM != 5'd0) &&
                   ((bus.use_rs_ID && (bus.rs_ID == bus.A3_MEM)) ||
                    (bus.use_rt_ID && (bus.rt_ID == bus.A3_MEM)));

  assign w_cnt_nz   = (r_cnt != '0);
  assign w_load_use = bus.Mem2Gpr_EX && w_hit_e;
  assign w_br_dep   = bus.branch_ID &&
                      ((bus.GprWrite_EX && w_hit_e) || (bus.Mem2Gpr_MEM && w_hit_m));
  assign w_md_dep   = bus.mnd_ID && (w_cnt_nz || bus.mnd_start_EX);
  assign w_stall    = w_load_use || w_br_dep || w_md_dep;
  assign w_take_int = bus.int_req && bus.IE && !r_exl;
  assign w_flush    = bus.Exception || w_take_int;

  always_comb begin
    bus.En_IF    = 1'b1;
    bus.En_ID    = 1'b1;
    bus.Clr_ID   = 1'b0;
    bus.Clr_EX   = 1'b0;
    bus.Clr_MEM  = 1'b0;
    bus.PC_sel   = 2'b00;
    bus.exl      = r_exl;
    bus.mnd_busy = w_cnt_nz && !Reset;
    if (Reset) begin
      bus.En_IF   = 1'b0;
      bus.En_ID   = 1'b0;
      bus.Clr_ID  = 1'b1;
      bus.Clr_EX  = 1'b1;
      bus.Clr_MEM = 1'b1;
    end else if (w_flush) begin
      bus.En_ID   = 1'b0;
      bus.Clr_ID  = 1'b1;
      bus.Clr_EX  = 1'b1;
      bus.Clr_MEM = 1'b1;
      bus.PC_sel  = 2'b01;
    end else if (bus.is_eret_MEM) begin
      // IF/ID is being cleared, so loading it would be wasted.
      bus.En_ID   = 1'b0;
      bus.Clr_ID  = 1'b1;
      bus.Clr_EX  = 1'b1;
      bus.PC_sel  = 2'b10;
    end else if (w_stall) begin
      bus.En_IF   = 1'b0;
      bus.En_ID   = 1'b0;
      bus.Clr_EX  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_exl <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_flush)
        r_exl <= 1'b1;
      else if (bus.is_eret_MEM)
        r_exl <= 1'b0;

      // The HI/LO unit runs independently of flushes: an issued op always completes.
      if (bus.mnd_start_EX && !w_cnt_nz)
        r_cnt <= bus.mnd_div_EX ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      else if (w_cnt_nz)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic Clk;
  logic Reset;
  int   n_chk;
  int   n_pass;
  int   stalls;
  int   busies;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {En_IF, En_ID, Clr_ID, Clr_EX, Clr_MEM, PC_sel}
  localparam logic [6:0] C_RST   = 7'b00_111_00;
  localparam logic [6:0] C_RUN   = 7'b11_000_00;
  localparam logic [6:0] C_STALL = 7'b00_010_00;
  localparam logic [6:0] C_EXC   = 7'b10_111_01;

  function automatic logic [6:0] ctl();
    return {bus.En_IF, bus.En_ID, bus.Clr_ID, bus.Clr_EX, bus.Clr_MEM, bus.PC_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.rs_ID = 5'd0; bus.rt_ID = 5'd0; bus.use_rs_ID = 1'b0; bus.use_rt_ID = 1'b0;
    bus.branch_ID = 1'b0; bus.mnd_ID = 1'b0; bus.A3_EX = 5'd0; bus.GprWrite_EX = 1'b0;
    bus.Mem2Gpr_EX = 1'b0; bus.mnd_start_EX = 1'b0; bus.mnd_div_EX = 1'b0;
    bus.A3_MEM = 5'd0; bus.Mem2Gpr_MEM = 1'b0; bus.Exception = 1'b0;
    bus.int_req = 1'b0; bus.IE = 1'b0; bus.is_eret_MEM = 1'b0;
  endtask

  // Next cycle: inputs change just after the falling edge, checks follow 1 ns later.
  task automatic next();
    @(negedge Clk);
  endtask

  // Holds an mfhi/mflo in ID after an issue and counts stall and busy cycles until release.
  task automatic measure(output int st, output int bz);
    st = 0;
    bz = 0;
    for (int i = 0; i < 30; i++) begin
      next();
      bus.mnd_start_EX = 1'b0;
      bus.mnd_ID = 1'b1;
      #1;
      if (bus.mnd_busy === 1'b1) bz++;
      if (ctl() !== C_STALL) break;
      st++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    idle();
    Reset = 1'b1;
    next(); next(); #1;
    chk("reset_ctl", ctl(), C_RST);
    chk("reset_busy", bus.mnd_busy, 0);
    chk("reset_exl", bus.exl, 0);

    next(); Reset = 1'b0; #1;
    chk("run_ctl", ctl(), C_RUN);

    // Load-use on rs
    next(); bus.Mem2Gpr_EX = 1'b1; bus.GprWrite_EX = 1'b1; bus.A3_EX = 5'd8;
    bus.rs_ID = 5'd8; bus.use_rs_ID = 1'b1; #1;
    chk("load_use_stall", ctl(), C_STALL);
    next(); bus.Mem2Gpr_EX = 1'b0; bus.GprWrite_EX = 1'b0; bus.A3_EX = 5'd0;
    bus.A3_MEM = 5'd8; bus.Mem2Gpr_MEM = 1'b1; #1;
    chk("load_use_release", ctl(), C_RUN);
    next(); idle(); bus.Mem2Gpr_EX = 1'b1; bus.GprWrite_EX = 1'b1; bus.A3_EX = 5'd0;
    bus.rs_ID = 5'd0; bus.use_rs_ID = 1'b1; #1;
    chk("load_use_r0", ctl(), C_RUN);
    next(); bus.A3_EX = 5'd8; bus.rs_ID = 5'd8; bus.use_rs_ID = 1'b0; #1;
    chk("load_use_unused_rs", ctl(), C_RUN);

    // Branch dependencies on rt
    next(); idle(); bus.branch_ID = 1'b1; bus.rt_ID = 5'd9; bus.use_rt_ID = 1'b1;
    bus.A3_MEM = 5'd9; bus.Mem2Gpr_MEM = 1'b1; #1;
    chk("br_mem_load_stall", ctl(), C_STALL);
    next(); bus.A3_MEM = 5'd0; bus.Mem2Gpr_MEM = 1'b0; #1;
    chk("br_mem_load_release", ctl(), C_RUN);
    next(); bus.GprWrite_EX = 1'b1; bus.A3_EX = 5'd9; #1;
    chk("br_ex_alu_stall", ctl(), C_STALL);
    next(); bus.GprWrite_EX = 1'b0; bus.A3_EX = 5'd0; bus.A3_MEM = 5'd9; #1;
    chk("br_mem_alu_run", ctl(), C_RUN);

    // div then mflo
    next(); idle(); bus.mnd_start_EX = 1'b1; bus.mnd_div_EX = 1'b1; bus.mnd_ID = 1'b1; #1;
    chk("div_issue_stall", ctl(), C_STALL);
    chk("div_issue_busy", bus.mnd_busy, 0);
    measure(stalls, busies);
    chk("div_stalls", stalls, 10);
    chk("div_busy", busies, 10);
    chk("div_release", ctl(), C_RUN);

    // mult then mfhi
    next(); idle(); bus.mnd_start_EX = 1'b1; bus.mnd_div_EX = 1'b0; bus.mnd_ID = 1'b1; #1;
    chk("mult_issue_stall", ctl(), C_STALL);
    measure(stalls, busies);
    chk("mult_stalls", stalls, 5);
    chk("mult_busy", busies, 5);

    // Exception during a load-use stall, masked interrupt, eret, then interrupt
    next(); idle(); bus.Mem2Gpr_EX = 1'b1; bus.A3_EX = 5'd8; bus.rs_ID = 5'd8;
    bus.use_rs_ID = 1'b1; bus.Exception = 1'b1; #1;
    chk("exc_over_stall", ctl(), C_EXC);
    next(); idle(); bus.int_req = 1'b1; bus.IE = 1'b1; #1;
    chk("exc_sets_exl", bus.exl, 1);
    chk("int_masked", ctl(), C_RUN);
    next(); bus.is_eret_MEM = 1'b1; #1;
    chk("eret_pc_sel", bus.PC_sel, 2'b10);
    chk("eret_clears", {bus.En_IF, bus.Clr_ID, bus.Clr_EX, bus.Clr_MEM}, 4'b1110);
    next(); bus.is_eret_MEM = 1'b0; #1;
    chk("eret_clears_exl", bus.exl, 0);
    chk("int_taken", ctl(), C_EXC);
    next(); idle(); #1;
    chk("int_sets_exl", bus.exl, 1);

    // Exception beats eret in the same cycle
    bus.Exception = 1'b1; bus.is_eret_MEM = 1'b1; #1;
    chk("exc_eret_ctl", ctl(), C_EXC);
    next(); idle(); #1;
    chk("exc_eret_exl", bus.exl, 1);

    // Counter loads despite a flush; reset mid-operation
    bus.mnd_start_EX = 1'b1; bus.mnd_div_EX = 1'b1; bus.Exception = 1'b1; #1;
    chk("start_with_exc", ctl(), C_EXC);
    next(); idle(); #1;
    chk("start_with_exc_busy", bus.mnd_busy, 1);
    next(); next(); next(); Reset = 1'b1; #1;
    chk("midop_reset_ctl", ctl(), C_RST);
    chk("midop_reset_busy", bus.mnd_busy, 0);
    next(); #1;
    chk("midop_reset_exl", bus.exl, 0);
    next(); Reset = 1'b0; #1;
    chk("post_reset_busy", bus.mnd_busy, 0);
    chk("post_reset_ctl", ctl(), C_RUN);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
